// File: rtl/control_unit_pkg.sv
// cpu_pkg: Mini SRC ISA opcodes, sequencer states, IR field positions and
// opcode classification helpers shared by the control unit and its bench.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_ROL  = 5'd4;
  localparam logic [4:0] OP_MUL  = 5'd5;
  localparam logic [4:0] OP_DIV  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_SHR  = 5'd8;
  localparam logic [4:0] OP_SHRA = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd10;
  localparam logic [4:0] OP_NOT  = 5'd11;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, X3, X4, X5, X6, HALT
  } state_t;

  function automatic logic is_binary(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROL, OP_ROR,
                      OP_SHR, OP_SHRA, OP_SHL};
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return op inside {OP_NOT, OP_NEG};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: IR/handshake inputs and every DataPath control line of the
// sequencer; master is the control unit, slave is the datapath side.
interface control_unit_if #(
  parameter int NREG = 16
);
  logic            w_run;
  logic            w_mem_rdy;
  logic [31:0]     w_IR;
  logic            s_PC, s_Zlow, s_Zhigh, s_MDR;
  logic [NREG-1:0] s_R;
  logic [NREG-1:0] e_R;
  logic            e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu;
  logic            w_IncPC, w_read;
  logic [5:0]      opcode;
  logic            w_halted, w_illegal;
  logic [15:0]     w_instr_cnt;

  modport master (
    input  w_run, w_mem_rdy, w_IR,
    output s_PC, s_Zlow, s_Zhigh, s_MDR, s_R, e_R,
           e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
           w_IncPC, w_read, opcode, w_halted, w_illegal, w_instr_cnt
  );

  modport slave (
    output w_run, w_mem_rdy, w_IR,
    input  s_PC, s_Zlow, s_Zhigh, s_MDR, s_R, e_R,
           e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu,
           w_IncPC, w_read, opcode, w_halted, w_illegal, w_instr_cnt
  );
endinterface

// File: rtl/control_unit_reg_select.sv
// reg_select: 4-bit register index to one-hot NREG vector, all zeros when
// disabled or when the index has no matching register.
module reg_select #(
  parameter int NREG = 16
) (
  input  logic            i_en,
  input  logic [3:0]      i_sel,
  output logic [NREG-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NREG; k++) begin
      o_onehot[k] = i_en && (32'(i_sel) == k);
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hard-wired Mini SRC sequencer, one control step per clock.
// Define MULDIV_EN to enable the mul/div LO/HI writeback path (X5/X6).
module control_unit #(
  parameter int NREG = 16
) (
  input logic            w_clock,
  input logic            w_clear,
  control_unit_if.master bus
);
  import cpu_pkg::*;

  state_t      r_state;
  logic        r_f1Wait;
  logic        r_halted;
  logic        r_illegal;
  logic [15:0] r_instrCnt;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc, w_selIdx;
  logic       w_isBin, w_isUn, w_isMulDiv, w_twoOp;
  logic       w_selEn, w_loadEn, w_unusedIr;

  assign w_op       = bus.w_IR[OP_MSB:OP_LSB];
  assign w_ra       = bus.w_IR[RA_MSB:RA_LSB];
  assign w_rb       = bus.w_IR[RB_MSB:RB_LSB];
  assign w_rc       = bus.w_IR[RC_MSB:RC_LSB];
  assign w_unusedIr = ^bus.w_IR[RC_LSB-1:0];

  assign w_isBin = is_binary(w_op);
  assign w_isUn  = is_unary(w_op);
`ifdef MULDIV_EN
  assign w_isMulDiv = is_muldiv(w_op);
`else
  assign w_isMulDiv = 1'b0;
`endif
  assign w_twoOp = w_isBin | w_isMulDiv;

  // Unary ops read their single operand (Rb) straight into the ALU in X4.
  assign w_selEn  = ((r_state == X3) && w_twoOp) || (r_state == X4);
  assign w_selIdx = (r_state == X3) ? w_rb :
                    (r_state == X4) ? (w_isUn ? w_rb : w_rc) : 4'd0;
  assign w_loadEn = (r_state == X5) && !w_isMulDiv;

  reg_select #(.NREG(NREG)) u_outSel (
    .i_en     (w_selEn),
    .i_sel    (w_selIdx),
    .o_onehot (bus.s_R)
  );

  reg_select #(.NREG(NREG)) u_loadSel (
    .i_en     (w_loadEn),
    .i_sel    (w_ra),
    .o_onehot (bus.e_R)
  );

  assign bus.s_PC    = (r_state == F0);
  assign bus.e_MAR   = (r_state == F0);
  assign bus.w_IncPC = (r_state == F0);
  assign bus.e_Z     = (r_state == F0) || (r_state == X4);
  assign bus.s_Zlow  = (r_state == F1) || (r_state == X5);
  assign bus.e_PC    = (r_state == F1) && !r_f1Wait;
  assign bus.w_read  = (r_state == F1);
  assign bus.e_MDR   = (r_state == F1);
  assign bus.s_MDR   = (r_state == F2);
  assign bus.e_IR    = (r_state == F2);
  assign bus.e_Y     = (r_state == X3) && w_twoOp;
  assign bus.e_alu   = (r_state == X4);
  assign bus.opcode  = (r_state == X4) ? {1'b0, w_op} : 6'd0;
`ifdef MULDIV_EN
  assign bus.s_Zhigh = (r_state == X6);
  assign bus.e_HI    = (r_state == X6);
  assign bus.e_LO    = (r_state == X5) && w_isMulDiv;
`else
  assign bus.s_Zhigh = 1'b0;
  assign bus.e_HI    = 1'b0;
  assign bus.e_LO    = 1'b0;
`endif

  assign bus.w_halted    = r_halted;
  assign bus.w_illegal   = r_illegal;
  assign bus.w_instr_cnt = r_instrCnt;

  // r_f1Wait marks F1 wait cycles so PC is reloaded only on the first one.
  always_ff @(posedge w_clock) begin
    if (!w_clear) begin
      r_state    <= IDLE;
      r_f1Wait   <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
      r_instrCnt <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (bus.w_run) r_state <= F0;
        F0: begin
          r_state  <= F1;
          r_f1Wait <= 1'b0;
        end
        F1: begin
          if (bus.w_mem_rdy) begin
            r_state  <= F2;
            r_f1Wait <= 1'b0;
          end else begin
            r_f1Wait <= 1'b1;
          end
        end
        F2: r_state <= X3;
        X3: begin
          if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else if (w_isBin || w_isUn || w_isMulDiv) begin
            r_state <= X4;
          end else begin
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= HALT;
          end
        end
        X4: r_state <= X5;
        X5: begin
          if (w_isMulDiv) begin
            r_state <= X6;
          end else begin
            r_instrCnt <= r_instrCnt + 16'd1;
            r_state    <= bus.w_run ? F0 : IDLE;
          end
        end
`ifdef MULDIV_EN
        X6: begin
          r_instrCnt <= r_instrCnt + 16'd1;
          r_state    <= bus.w_run ? F0 : IDLE;
        end
`endif
        HALT: r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed sequence for the Mini SRC control unit; expected
// control vectors are queued per step and checked at the following negedge.
module tb_control_unit;

  localparam logic [31:0] IR_ADD  = 32'h00918000;
  localparam logic [31:0] IR_NEG  = 32'h61100000;
  localparam logic [31:0] IR_MUL  = 32'h2A980000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  typedef struct packed {
    logic        sPC, sZlow, sZhigh, sMDR;
    logic [15:0] sR;
    logic [15:0] eR;
    logic        eMAR, eZ, ePC, eMDR, eIR, eY, eHI, eLO, eAlu, incPC, read;
    logic [5:0]  opcode;
    logic        halted, illegal;
    logic [15:0] cnt;
  } obs_t;

  logic clock = 1'b0;
  logic clear;
  int   checks = 0;
  int   failures = 0;
  obs_t  expQ[$];
  string tagQ[$];

  control_unit_if #(.NREG(16)) bus ();

  control_unit #(.NREG(16)) dut (
    .w_clock (clock),
    .w_clear (clear),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic obs_t blank(input logic [15:0] cnt, input logic h, input logic il);
    obs_t o;
    o = '0;
    o.cnt = cnt;
    o.halted = h;
    o.illegal = il;
    return o;
  endfunction

  function automatic obs_t stF0(input logic [15:0] cnt);
    obs_t o = blank(cnt, 1'b0, 1'b0);
    o.sPC = 1'b1; o.eMAR = 1'b1; o.incPC = 1'b1; o.eZ = 1'b1;
    return o;
  endfunction

  function automatic obs_t stF1(input logic [15:0] cnt, input logic first);
    obs_t o = blank(cnt, 1'b0, 1'b0);
    o.sZlow = 1'b1; o.ePC = first; o.read = 1'b1; o.eMDR = 1'b1;
    return o;
  endfunction

  function automatic obs_t stF2(input logic [15:0] cnt);
    obs_t o = blank(cnt, 1'b0, 1'b0);
    o.sMDR = 1'b1; o.eIR = 1'b1;
    return o;
  endfunction

  function automatic obs_t stX3(input logic [15:0] cnt, input logic [15:0] sR, input logic eY);
    obs_t o = blank(cnt, 1'b0, 1'b0);
    o.sR = sR; o.eY = eY;
    return o;
  endfunction

  function automatic obs_t stX4(input logic [15:0] cnt, input logic [15:0] sR, input logic [5:0] op);
    obs_t o = blank(cnt, 1'b0, 1'b0);
    o.sR = sR; o.eAlu = 1'b1; o.eZ = 1'b1; o.opcode = op;
    return o;
  endfunction

  function automatic obs_t stX5(input logic [15:0] cnt, input logic [15:0] eR);
    obs_t o = blank(cnt, 1'b0, 1'b0);
    o.sZlow = 1'b1; o.eR = eR;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.sPC = bus.s_PC; o.sZlow = bus.s_Zlow; o.sZhigh = bus.s_Zhigh; o.sMDR = bus.s_MDR;
    o.sR = bus.s_R; o.eR = bus.e_R;
    o.eMAR = bus.e_MAR; o.eZ = bus.e_Z; o.ePC = bus.e_PC; o.eMDR = bus.e_MDR;
    o.eIR = bus.e_IR; o.eY = bus.e_Y; o.eHI = bus.e_HI; o.eLO = bus.e_LO;
    o.eAlu = bus.e_alu; o.incPC = bus.w_IncPC; o.read = bus.w_read;
    o.opcode = bus.opcode;
    o.halted = bus.w_halted; o.illegal = bus.w_illegal; o.cnt = bus.w_instr_cnt;
    return o;
  endfunction

  task automatic checkOutput();
    obs_t  got;
    obs_t  exp;
    string tag;
    got = observe();
    exp = expQ.pop_front();
    tag = tagQ.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input obs_t exp);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  initial begin
    clear = 1'b0;
    bus.w_run = 1'b1;
    bus.w_mem_rdy = 1'b1;
    bus.w_IR = IR_ADD;
    applyStimulus("reset", blank(16'd0, 1'b0, 1'b0));
    clear = 1'b1;

    // add R1,R2,R3 with no wait states
    applyStimulus("add_F0", stF0(16'd0));
    applyStimulus("add_F1", stF1(16'd0, 1'b1));
    applyStimulus("add_F2", stF2(16'd0));
    applyStimulus("add_X3", stX3(16'd0, 16'h0004, 1'b1));
    applyStimulus("add_X4", stX4(16'd0, 16'h0008, 6'd0));
    applyStimulus("add_X5", stX5(16'd0, 16'h0002));
    applyStimulus("add2_F0", stF0(16'd1));

    // same instruction with three memory wait cycles, run dropped mid-way
    bus.w_mem_rdy = 1'b0;
    applyStimulus("wait_F1a", stF1(16'd1, 1'b1));
    applyStimulus("wait_F1b", stF1(16'd1, 1'b0));
    applyStimulus("wait_F1c", stF1(16'd1, 1'b0));
    applyStimulus("wait_F1d", stF1(16'd1, 1'b0));
    bus.w_mem_rdy = 1'b1;
    applyStimulus("wait_F2", stF2(16'd1));
    applyStimulus("wait_X3", stX3(16'd1, 16'h0004, 1'b1));
    bus.w_run = 1'b0;
    applyStimulus("wait_X4", stX4(16'd1, 16'h0008, 6'd0));
    applyStimulus("wait_X5", stX5(16'd1, 16'h0002));
    applyStimulus("idle_after_add", blank(16'd2, 1'b0, 1'b0));
    applyStimulus("idle_hold", blank(16'd2, 1'b0, 1'b0));

    // neg R2,R2
    bus.w_IR = IR_NEG;
    bus.w_run = 1'b1;
    applyStimulus("neg_F0", stF0(16'd2));
    applyStimulus("neg_F1", stF1(16'd2, 1'b1));
    applyStimulus("neg_F2", stF2(16'd2));
    applyStimulus("neg_X3", stX3(16'd2, 16'h0000, 1'b0));
    bus.w_run = 1'b0;
    applyStimulus("neg_X4", stX4(16'd2, 16'h0004, 6'd12));
    applyStimulus("neg_X5", stX5(16'd2, 16'h0004));
    applyStimulus("idle_after_neg", blank(16'd3, 1'b0, 1'b0));

    // mul R5,R3
    bus.w_IR = IR_MUL;
    bus.w_run = 1'b1;
    applyStimulus("mul_F0", stF0(16'd3));
    applyStimulus("mul_F1", stF1(16'd3, 1'b1));
    applyStimulus("mul_F2", stF2(16'd3));
`ifdef MULDIV_EN
    applyStimulus("mul_X3", stX3(16'd3, 16'h0008, 1'b1));
    bus.w_run = 1'b0;
    applyStimulus("mul_X4", stX4(16'd3, 16'h0001, 6'd5));
    begin
      obs_t e;
      e = blank(16'd3, 1'b0, 1'b0);
      e.sZlow = 1'b1; e.eLO = 1'b1;
      applyStimulus("mul_X5", e);
      e = blank(16'd3, 1'b0, 1'b0);
      e.sZhigh = 1'b1; e.eHI = 1'b1;
      applyStimulus("mul_X6", e);
    end
    applyStimulus("idle_after_mul", blank(16'd4, 1'b0, 1'b0));
`else
    applyStimulus("mul_X3_illegal", stX3(16'd3, 16'h0000, 1'b0));
    applyStimulus("mul_halt", blank(16'd3, 1'b1, 1'b1));
    applyStimulus("mul_halt_hold", blank(16'd3, 1'b1, 1'b1));
`endif
    bus.w_run = 1'b0;
    clear = 1'b0;
    applyStimulus("reset2", blank(16'd0, 1'b0, 1'b0));
    clear = 1'b1;
    applyStimulus("idle_run_low", blank(16'd0, 1'b0, 1'b0));

    // halt instruction, held with run high
    bus.w_IR = IR_HALT;
    bus.w_run = 1'b1;
    applyStimulus("halt_F0", stF0(16'd0));
    applyStimulus("halt_F1", stF1(16'd0, 1'b1));
    applyStimulus("halt_F2", stF2(16'd0));
    applyStimulus("halt_X3", stX3(16'd0, 16'h0000, 1'b0));
    for (int i = 0; i < 20; i++) begin
      applyStimulus("halt_hold", blank(16'd0, 1'b1, 1'b0));
    end
    clear = 1'b0;
    applyStimulus("halt_reset", blank(16'd0, 1'b0, 1'b0));
    bus.w_IR = IR_ADD;
    clear = 1'b1;

    // one full add, then reset during X4 of the next one
    applyStimulus("r_F0", stF0(16'd0));
    applyStimulus("r_F1", stF1(16'd0, 1'b1));
    applyStimulus("r_F2", stF2(16'd0));
    applyStimulus("r_X3", stX3(16'd0, 16'h0004, 1'b1));
    applyStimulus("r_X4", stX4(16'd0, 16'h0008, 6'd0));
    applyStimulus("r_X5", stX5(16'd0, 16'h0002));
    applyStimulus("r2_F0", stF0(16'd1));
    applyStimulus("r2_F1", stF1(16'd1, 1'b1));
    applyStimulus("r2_F2", stF2(16'd1));
    applyStimulus("r2_X3", stX3(16'd1, 16'h0004, 1'b1));
    applyStimulus("r2_X4", stX4(16'd1, 16'h0008, 6'd0));
    clear = 1'b0;
    applyStimulus("x4_reset", blank(16'd0, 1'b0, 1'b0));
    clear = 1'b1;
    applyStimulus("restart_F0", stF0(16'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hard-wired sequencer for the Mini SRC datapath: decodes the instruction held in IR and drives every bus-select and register-enable line of `DataPath`, one control step per clock. It replaces the hand-sequenced T0–T5 stimulus used in bring-up and sits beside `DataPath` in the CPU top level. It handles instruction fetch with memory wait states, three-operand and unary ALU ops, optional mul/div into HI/LO, and halt/illegal detection.

## Interface
Parameters:
- `NREG`, 16, number of general registers; sets the width of the one-hot register vectors.

Ports:
- `w_clock`  in  1  system clock; all state changes on the rising edge.
- `w_clear`  in  1  reset, synchronous, active-low.
- `w_run`  in  1  level; while high, the unit leaves IDLE and keeps executing.
- `w_mem_rdy`  in  1  memory read data valid on `w_Mdatain` this cycle.
- `w_IR`  in  32  current IR contents: op[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- `s_PC`, `s_Zlow`, `s_Zhigh`, `s_MDR`  out  1 each  bus-source selects.
- `s_R`  out  NREG  one-hot register bus-source select.
- `e_R`  out  NREG  one-hot register load enable.
- `e_MAR`, `e_Z`, `e_PC`, `e_MDR`, `e_IR`, `e_Y`, `e_HI`, `e_LO`, `e_alu`  out  1 each  load enables.
- `w_IncPC`, `w_read`  out  1 each  PC-increment mode and memory read strobe.
- `opcode`  out  6  ALU op, equal to {1'b0, op}.
- `w_halted`, `w_illegal`  out  1 each  sticky status flags.
- `w_instr_cnt`  out  16  count of retired instructions.

## Operation
- States: IDLE, F0, F1, F2, X3, X4, X5, X6, HALT.
- IDLE: all controls are 0. Go to F0 when `w_run`=1.
- F0: `s_PC`, `e_MAR`, `w_IncPC`, `e_Z`.
- F1: `s_Zlow`, `e_PC` (first F1 cycle only), `w_read`, `e_MDR`.
  - Stay in F1 while `w_mem_rdy`=0. PC is not reloaded on wait cycles.
  - Go to F2 on the cycle where `w_mem_rdy`=1.
- F2: `s_MDR`, `e_IR`. Go to X3.
- Decode from `w_IR` in X3. Op classes are defined in the package.
  - Binary ops (add, sub, and, or, rol, ror, shr, shra, shl):
    - X3: `s_R[Rb]`, `e_Y`.
    - X4: `s_R[Rc]`, `e_alu`, `e_Z`.
    - X5: `s_Zlow`, `e_R[Ra]`.
  - Unary ops (not, neg):
    - X3 asserts no controls.
    - X4: `s_R[Rb]`, `e_alu`, `e_Z`.
    - X5 as for binary ops.
  - mul/div:
    - X3 and X4 as for binary ops.
    - X5: `s_Zlow`, `e_LO`.
    - X6: `s_Zhigh`, `e_HI`.
  - halt (op 5'b11011): set `w_halted`, go to HALT.
  - Any other op: set `w_illegal` and `w_halted`, go to HALT.
- End of instruction (X5, or X6 for mul/div):
  - Increment `w_instr_cnt`; it wraps 0xFFFF→0x0000.
  - Go to F0 if `w_run`=1, else IDLE.
- `opcode` carries its value during X4 only and is 0 otherwise.
- HALT: all controls are 0. Only reset leaves HALT. `w_run` is ignored.
- `w_run` dropping mid-instruction does not abort; the instruction completes.

## Timing
- Controls are Moore outputs, decoded combinationally from the registered state and `w_IR`.
- `w_clear`=0 at an edge has these effects on that edge:
  - state becomes IDLE;
  - `w_instr_cnt`, `w_halted` and `w_illegal` become 0;
  - all control outputs become 0.
- Reset overrides `w_run` and `w_mem_rdy`, including mid-fetch and mid-execute.
- Latency without wait states:
  - ALU instruction: 6 cycles, F0 to X5.
  - mul/div: 7 cycles.
  - Each `w_mem_rdy`=0 cycle in F1 adds one cycle.
- First F0 is one cycle after `w_run` is sampled high in IDLE.
- `e_PC` is high in exactly one cycle per instruction.
- `w_read` stays high for every F1 cycle.

## Configuration
- `MULDIV_EN` defined:
  - mul and div use the X5/X6 LO/HI path.
  - `s_Zhigh`, `e_HI` and `e_LO` are driven.
- `MULDIV_EN` undefined:
  - mul and div decode as illegal.
  - `s_Zhigh`, `e_HI` and `e_LO` are tied to 0.
  - X6 is not synthesized.

## Structure
- Package `cpu_pkg` holds:
  - the 5-bit ISA opcode constants (add=0 … neg=12, halt=27);
  - the state enumeration;
  - IR field bit positions;
  - the `is_binary`, `is_unary` and `is_muldiv` classification functions.
- Sub-module `reg_select`: combinational 4-to-NREG one-hot decoder, instanced twice.
  - Instance 1 (out-select): driven by Rb in X3, Rc or Rb in X4, and all zeros otherwise.
  - Instance 2 (load enable): driven by Ra in X5.

## Test plan
- Reset with `w_run`=1, IR=0x00918000 (add R1,R2,R3), `w_mem_rdy` always 1 → states F0,F1,F2,X3,X4,X5; `s_R`=0x0004 in X3, `s_R`=0x0008 with `opcode`=0 in X4, `e_R`=0x0002 in X5; `w_instr_cnt`=1.
- Same instruction with `w_mem_rdy` low for 3 cycles → F1 lasts 4 cycles, `e_PC` pulses once, `w_read` high for all 4; 9 cycles total.
- IR=0x61100000 (neg R2,R2) → X3 has no controls; X4 has `s_R`=0x0004 and `opcode`=12; X5 has `e_R`=0x0004.
- IR=0x2A980000 (mul R5,R3) with `MULDIV_EN` → `e_LO` in X5, `s_Zhigh`+`e_HI` in X6. Without the macro → `w_illegal`=1, then HALT.
- IR=0xD8000000 (halt) → `w_halted`=1, all outputs 0; state stays HALT for 20 cycles with `w_run`=1; `w_clear`=0 returns to IDLE.
- `w_clear` pulled low during X4 → next edge: IDLE, all controls 0, `w_instr_cnt`=0; `w_run`=1 restarts at F0.
